// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the fetch-stage PC sequencer.
// Optional feature macro used by this slice: ADEL_CHECK_EN (fetch address-error check).
package fetch_pkg;

  // Default reset PC and exception entry point of the core
  localparam logic [31:0] DefResetPc   = 32'h0000_3000;
  localparam logic [31:0] DefExcVector = 32'h0000_4180;

  // Legal instruction-fetch window, only consulted when ADEL_CHECK_EN is defined
  localparam logic [31:0] PcMin = 32'h0000_3000;
  localparam logic [31:0] PcMax = 32'h0000_6FFC;

  // CP0 ExcCode reported for an address error on instruction fetch
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Sequencer states
  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  // Winning redirect request
  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } redirect_t;

  // True when a fetch from this address must raise AdEL instead of going to memory
  function automatic logic fetch_addr_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PcMin) || (pc > PcMax);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch handshake: req/addr from the sequencer, ack back from memory.
// The address is held stable while the request is high; an ack closes the request.
interface fetch_pc_ctrl_if;
  import fetch_pkg::*;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;

  // Fetch sequencer side
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i
  );

  // Instruction memory side
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Priority select of the next redirect: exception > ERET > branch/jump.
// Branches are masked while the hazard unit stalls; exceptions and ERET are not.
module pc_redirect_arb
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output redirect_t   redir_o
);

  // Only the highest-priority source is taken; lower ones are simply dropped
  always_comb begin
    redir_o.valid  = 1'b0;
    redir_o.target = '0;
    if (exc_req_i) begin
      redir_o.valid  = 1'b1;
      redir_o.target = EXC_VECTOR;
    end else if (eret_i) begin
      redir_o.valid  = 1'b1;
      redir_o.target = epc_i;
    end else if (br_valid_i && !stall_i) begin
      redir_o.valid  = 1'b1;
      redir_o.target = br_target_i;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer owning the PC: sequential fetch, redirects, stall hold and
// draining of a request that was abandoned by a redirect.
// Optional feature macro: ADEL_CHECK_EN -- when defined, out-of-window or misaligned
// fetch addresses raise if_exc_o instead of issuing a memory request.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefResetPc,
  parameter logic [31:0] EXC_VECTOR = DefExcVector
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   br_valid_i,
  input  logic [31:0]            br_target_i,
  input  logic                   exc_req_i,
  input  logic                   eret_i,
  input  logic [31:0]            epc_i,
  fetch_pc_ctrl_if.master        imem,
  output logic                   if_valid_o,
  output logic [31:0]            if_pc_o,
  output logic                   flush_o,
  output logic                   if_exc_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         flush_q;
  logic         imem_req;
  logic         adel_fault;
  redirect_t    redir;

  pc_redirect_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .br_target_i (br_target_i),
    .exc_req_i   (exc_req_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .redir_o     (redir)
  );

`ifdef ADEL_CHECK_EN
  assign adel_fault = fetch_addr_bad(pc_q);
`else
  assign adel_fault = 1'b0;
`endif

  // Next-state, next-PC and handshake outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req   = 1'b0;
    if_valid_o = 1'b0;
    if_exc_o   = 1'b0;

    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        if (redir.valid) pc_d = redir.target;
      end

      StFetch: begin
        if (adel_fault) begin
          // Faulting address: offer the AdEL to IF/ID until something redirects us
          if (redir.valid) begin
            pc_d = redir.target;
          end else begin
            if_valid_o = 1'b1;
            if_exc_o   = 1'b1;
          end
        end else begin
          imem_req = 1'b1;
          if (redir.valid) begin
            pc_d    = redir.target;
            // Without an ack the request stays open in memory and must be drained
            state_d = imem.imem_ack_i ? StFetch : StDrain;
          end else if (imem.imem_ack_i) begin
            if (stall_i) begin
              state_d = StHold;
            end else begin
              if_valid_o = 1'b1;
              pc_d       = pc_q + 32'd4;
            end
          end
        end
      end

      StHold: begin
        // pc_q still holds the captured PC, so if_pc_o stays frozen here
        if (redir.valid) begin
          pc_d    = redir.target;
          state_d = StFetch;
        end else begin
          if_valid_o = 1'b1;
          if (!stall_i) begin
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
          end
        end
      end

      StDrain: begin
        // The stale ack is discarded; a redirect here only retargets pc_q
        if (redir.valid) pc_d = redir.target;
        if (imem.imem_ack_i) state_d = StFetch;
      end
    endcase
  end

  // State, PC and flush registers; reset aborts any pending request immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= redir.valid;
    end
  end

  assign imem.imem_req_o  = imem_req;
  assign imem.imem_addr_o = pc_q;
  assign if_pc_o          = pc_q;
  assign flush_o          = flush_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized traffic,
// all compared each cycle against a flag-based behavioural model of the fetch stage.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RstPc  = 32'h0000_3000;
  localparam logic [31:0] ExcVec = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        flush;
  logic        if_exc;

  fetch_pc_ctrl_if imem ();

  fetch_pc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall),
    .br_valid_i  (br_valid),
    .br_target_i (br_target),
    .exc_req_i   (exc_req),
    .eret_i      (eret),
    .epc_i       (epc),
    .imem        (imem),
    .if_valid_o  (if_valid),
    .if_pc_o     (if_pc),
    .flush_o     (flush),
    .if_exc_o    (if_exc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the fetch stage
  logic [31:0] m_pc;
  bit          m_boot, m_hold, m_stale, m_flush;
  // Expected values for the current cycle
  bit          e_req, e_valid, e_exc, r_take;
  logic [31:0] r_tgt;
  // Memory responder: a request seen and not yet acked
  bit          pend = 1'b0;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef ADEL_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RstPc; m_boot = 1; m_hold = 0; m_stale = 0; m_flush = 0;
  endtask

  // Expected outputs from the model state and the inputs of this cycle
  task automatic model_outputs();
    bit fetching, bad;
    fetching = !m_boot && !m_hold && !m_stale;
    bad      = fetching && addr_bad(m_pc);
    r_take   = 1'b1;
    if (exc_req)                  r_tgt = ExcVec;
    else if (eret)                r_tgt = epc;
    else if (br_valid && !stall)  r_tgt = br_target;
    else begin r_take = 1'b0; r_tgt = m_pc; end
    e_req   = fetching && !bad;
    e_exc   = bad && !r_take;
    e_valid = !r_take && (m_hold || bad || (e_req && imem.imem_ack_i && !stall));
  endtask

  // Model update at the clock edge
  task automatic model_step();
    bit ack;
    ack = imem.imem_ack_i;
    if (r_take) begin
      m_stale = (e_req || m_stale) && !ack;
      m_pc    = r_tgt;
      m_boot  = 0;
      m_hold  = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_hold) begin
      if (!stall) begin m_hold = 0; m_pc = m_pc + 32'd4; end
    end else if (m_stale) begin
      if (ack) m_stale = 0;
    end else if (e_req && ack) begin
      if (stall) m_hold = 1;
      else       m_pc = m_pc + 32'd4;
    end
    m_flush = r_take;
  endtask

  task automatic compare();
    check("req", {31'd0, imem.imem_req_o}, {31'd0, e_req});
    check("if_valid", {31'd0, if_valid}, {31'd0, e_valid});
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("if_exc", {31'd0, if_exc}, {31'd0, e_exc});
    if (e_req)   check("addr", imem.imem_addr_o, m_pc);
    if (e_valid) check("if_pc", if_pc, m_pc);
  endtask

  // Called at posedge+1: apply inputs, compare at the falling edge
  task automatic drive(input bit st, input bit br, input logic [31:0] bt, input bit ex,
                       input bit er, input logic [31:0] ep, input bit ack);
    stall = st; br_valid = br; br_target = bt; exc_req = ex; eret = er; epc = ep;
    imem.imem_ack_i = ack;
    model_outputs();
    #4;
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) model_step();
    if (imem.imem_ack_i) pend = 0;
    #1;
    if (imem.imem_req_o) pend = 1;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'h0000_3000 + ($urandom_range(0, 32'hFFF) << 2);
    if ($urandom_range(0, 15) == 0) t = t | 32'd2;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    imem.imem_ack_i = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_req", {31'd0, imem.imem_req_o}, 32'd0);
    check("rst_addr", imem.imem_addr_o, RstPc);
    check("rst_if_pc", if_pc, RstPc);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Boot cycle, then sequential fetch
    drive(0, 0, 0, 0, 0, 0, 0);
    check("boot_req", {31'd0, imem.imem_req_o}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("seq_addr0", imem.imem_addr_o, 32'h3000);
    check("seq_valid0", {31'd0, if_valid}, 32'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("seq_addr1", imem.imem_addr_o, 32'h3004);
    advance();

    // Ack with stall: hold 0x3008
    drive(1, 0, 0, 0, 0, 0, 1);
    check("seq_addr2", imem.imem_addr_o, 32'h3008);
    advance();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("hold_req", {31'd0, imem.imem_req_o}, 32'd0);
    check("hold_pc", if_pc, 32'h3008);
    check("hold_valid", {31'd0, if_valid}, 32'd1);
    advance();
    drive(1, 0, 0, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hold_pc_rel", if_pc, 32'h3008);
    advance();

    // Branch without ack: drain the stale ack
    drive(0, 1, 32'h3100, 0, 0, 0, 0);
    check("after_hold_addr", imem.imem_addr_o, 32'h300C);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("drain_req", {31'd0, imem.imem_req_o}, 32'd0);
    check("drain_flush", {31'd0, flush}, 32'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("stale_valid", {31'd0, if_valid}, 32'd0);
    check("flush_1pulse", {31'd0, flush}, 32'd0);
    advance();

    // All three sources at once: exception wins
    drive(0, 1, 32'h3300, 1, 1, 32'h3200, 1);
    check("br_addr", imem.imem_addr_o, 32'h3100);
    check("redir_valid0", {31'd0, if_valid}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("exc_addr", imem.imem_addr_o, ExcVec);
    check("exc_flush", {31'd0, flush}, 32'd1);
    advance();

    // Stalled branch ignored, stalled exception taken
    drive(1, 1, 32'h3500, 0, 0, 0, 0);
    advance();
    drive(1, 0, 0, 1, 0, 0, 0);
    check("br_stall_ign", imem.imem_addr_o, ExcVec);
    check("br_stall_noflush", {31'd0, flush}, 32'd0);
    advance();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("exc_stall_flush", {31'd0, flush}, 32'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();

`ifdef ADEL_CHECK_EN
    // Misaligned target: no request, AdEL offered until redirected
    drive(0, 1, 32'h3002, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("adel_req", {31'd0, imem.imem_req_o}, 32'd0);
    check("adel_exc", {31'd0, if_exc}, 32'd1);
    check("adel_pc", if_pc, 32'h3002);
    advance();
    drive(0, 1, 32'h3000, 0, 0, 0, 0);
    advance();
`else
    // PC wraps modulo 2^32
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("wrap_addr", imem.imem_addr_o, 32'h0);
    advance();
`endif

    // Reset asserted mid-FETCH drops the request at once; a late ack is ignored
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, imem.imem_req_o}, 32'd0);
    check("mid_rst_addr", imem.imem_addr_o, RstPc);
    model_reset();
    pend = 0;
    advance();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("restart_addr", imem.imem_addr_o, 32'h3000);
    check("restart_req", {31'd0, imem.imem_req_o}, 32'd1);
    advance();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rand_tgt(),
            $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, rand_tgt(),
            pend && ($urandom_range(0, 1) == 1));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
